// File: rtl/adder_share_arb.sv
// Round-robin arbiter/sequencer that shares one external adder among NREQ requesters.
// IDLE grants one request, ISSUE drives registered operands for one cycle, RESP returns the result.
module adder_share_arb #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned OP_LEN = 5,
  parameter int unsigned NREQ   = 4,
  parameter int unsigned ID_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  input  logic [NREQ*OP_LEN-1:0]   req_op,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic [OP_LEN-1:0]        add_opcode,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic [3:0]               add_flags,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic [3:0]               rsp_flags,
  output logic                     rsp_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]      state_q;
  logic [1:0]      state_d;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] idx_c;
  logic [ID_W-1:0] win_c;
  logic            win_vld_c;
  logic            accept_c;
  logic            op_legal_c;

  // First valid requester at or after ptr, wrapping modulo NREQ
  always_comb begin
    idx_c     = '0;
    win_c     = '0;
    win_vld_c = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx_c = ID_W'((32'(ptr_q) + k) % NREQ);
      if (!win_vld_c && req_valid[idx_c]) begin
        win_c     = idx_c;
        win_vld_c = 1'b1;
      end
    end
  end

  assign accept_c   = (state_q == S_IDLE) && win_vld_c;
  assign op_legal_c = (add_opcode == OP_LEN'(1)) || (add_opcode == OP_LEN'(2)) ||
                      (add_opcode == OP_LEN'(3));

  // Grant is combinational and forced low while reset is asserted
  always_comb begin
    req_ready = '0;
    if (rst_n && accept_c) begin
      req_ready = NREQ'(1) << win_c;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_c) state_d = S_ISSUE;
      S_ISSUE: state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand launch on accept, result capture at the end of ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      add_a      <= '0;
      add_b      <= '0;
      add_opcode <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_sum    <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= (state_d == S_RESP);
      if (accept_c) begin
        add_a      <= req_a[32'(win_c) * WIDTH +: WIDTH];
        add_b      <= req_b[32'(win_c) * WIDTH +: WIDTH];
        add_opcode <= req_op[32'(win_c) * OP_LEN +: OP_LEN];
        rsp_id     <= win_c;
        ptr_q      <= ID_W'((32'(win_c) + 32'd1) % NREQ);
      end
      if (state_q == S_ISSUE) begin
        rsp_sum   <= add_sum;
        rsp_flags <= add_flags;
        rsp_err   <= !op_legal_c;
      end
    end
  end

endmodule

// File: tb/tb_adder_share_arb.sv
// Scoreboard bench for adder_share_arb: a behavioural adder, round-robin model and
// response queue checked by an independent monitor.
module tb_adder_share_arb;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int OPL = 5;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [OPL-1:0] op;
    bit             has_exp;
    logic [W-1:0]   es;
    logic [3:0]     ef;
    logic           ee;
  } req_t;

  typedef struct {
    logic [1:0]   id;
    logic [W-1:0] sum;
    logic [3:0]   flags;
    logic         err;
  } rsp_t;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N*OPL-1:0] req_op;
  logic [W-1:0]     add_a;
  logic [W-1:0]     add_b;
  logic [OPL-1:0]   add_opcode;
  logic [W-1:0]     add_sum;
  logic [3:0]       add_flags;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [W-1:0]     rsp_sum;
  logic [3:0]       rsp_flags;
  logic             rsp_err;

  adder_share_arb #(.WIDTH(W), .OP_LEN(OPL), .NREQ(N), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .add_a(add_a), .add_b(add_b), .add_opcode(add_opcode),
    .add_sum(add_sum), .add_flags(add_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference adder: returns {sum, cout, negative, overflow, zero}
  function automatic logic [W+3:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [OPL-1:0] op);
    logic [W:0] s;
    logic       ovf;
    case (op)
      5'd1: begin s = {1'b0, a} + {1'b0, b}; ovf = 1'b0; end
      5'd2: begin s = {1'b0, a} + {1'b0, b}; ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]); end
      5'd3: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; ovf = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]); end
      default: return {32'd0, 4'b0001};
    endcase
    return {s[W-1:0], s[W], s[W-1], ovf, (s[W-1:0] == 32'd0)};
  endfunction

  always_comb {add_sum, add_flags} = ref_add(add_a, add_b, add_opcode);

  int   total = 0;
  int   bad = 0;
  req_t rq[N][$];
  req_t cur[N];
  logic [N-1:0] v;
  rsp_t sb[$];
  int   grants[$];
  int   grant_t[$];
  int   ptr = 0;
  bit   busy = 0;
  int   age = 0;
  bit   acc_pend = 0;
  int   acc_w = 0;
  int   step_cnt = 0;
  bit   rand_gate = 0;
  int   rr_mode = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W]     = cur[i].a;
      req_b[i*W +: W]     = cur[i].b;
      req_op[i*OPL +: OPL] = cur[i].op;
    end
  endtask

  // One clock of stimulus plus grant/valid checking against the arbitration model
  task automatic step();
    int         w;
    logic [N-1:0] exp_rdy;
    logic       exp_rv;
    logic [W+3:0] r;
    rsp_t       e;
    @(negedge clk);
    step_cnt++;
    if (acc_pend) begin v[acc_w] = 1'b0; acc_pend = 0; end
    for (int i = 0; i < N; i++) begin
      if (!v[i] && rq[i].size() != 0 && (!rand_gate || $urandom_range(0, 2) == 0)) begin
        cur[i] = rq[i].pop_front();
        v[i]   = 1'b1;
      end
    end
    case (rr_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = 1'($urandom_range(0, 1));
      default: rsp_ready = 1'b0;
    endcase
    drive();
    #1;
    if (busy) age++;
    exp_rv = busy && (age >= 2);
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    exp_rdy = '0;
    w = -1;
    if (!busy) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (ptr + k) % N;
        if (w < 0 && v[j]) w = j;
      end
    end
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (exp_rv && rsp_ready) busy = 0;
    if (w >= 0) begin
      e.id = 2'(w);
      if (cur[w].has_exp) begin
        e.sum = cur[w].es; e.flags = cur[w].ef; e.err = cur[w].ee;
      end else begin
        r = ref_add(cur[w].a, cur[w].b, cur[w].op);
        e.sum   = r[W+3:4];
        e.flags = r[3:0];
        e.err   = !(cur[w].op == 5'd1 || cur[w].op == 5'd2 || cur[w].op == 5'd3);
      end
      sb.push_back(e);
      ptr = (w + 1) % N;
      busy = 1; age = 0; acc_pend = 1; acc_w = w;
      grants.push_back(w);
      grant_t.push_back(step_cnt);
    end
  endtask

  function automatic bit pending();
    bit p;
    p = busy || (v != '0);
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) p = 1;
    return p;
  endfunction

  task automatic drain(input int max_steps);
    int n;
    n = 0;
    while (pending() && n < max_steps) begin step(); n++; end
    chk("drain_done", 64'(pending()), 64'(0));
  endtask

  task automatic push_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [OPL-1:0] op, input bit he, input logic [W-1:0] es,
                          input logic [3:0] ef, input logic ee);
    req_t q;
    q.a = a; q.b = b; q.op = op; q.has_exp = he; q.es = es; q.ef = ef; q.ee = ee;
    rq[id].push_back(q);
  endtask

  task automatic push_rand(input int id);
    logic [OPL-1:0] op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    int sel;
    sel = $urandom_range(0, 7);
    op  = (sel < 6) ? OPL'(sel % 3 + 1) : OPL'($urandom_range(0, 31));
    a   = $urandom();
    b   = ($urandom_range(0, 5) == 0) ? a : $urandom();
    if ($urandom_range(0, 7) == 0) a = 32'h7FFF_FFFF;
    push_req(id, a, b, op, 0, '0, '0, 1'b0);
  endtask

  task automatic wait_rsp_valid(input string nm);
    int n;
    n = 0;
    while (!(busy && age >= 2) && n < 20) begin step(); n++; end
    chk(nm, 64'(rsp_valid), 64'(1));
  endtask

  // Monitor: compares the presented response to the queue head; pops on handshake
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
        end else begin
          e = sb[0];
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
          chk("rsp_sum", 64'(rsp_sum), 64'(e.sum));
          chk("rsp_flags", 64'(rsp_flags), 64'(e.flags));
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          if (rsp_ready) sb.delete(0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      cur[i].a = '0; cur[i].b = '0; cur[i].op = '0; cur[i].has_exp = 0;
      cur[i].es = '0; cur[i].ef = '0; cur[i].ee = 1'b0;
    end
    v = '0;
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    drive();
    req_valid = '1;
    #35;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_id", 64'(rsp_id), 64'(0));
    chk("rst_rsp_sum", 64'(rsp_sum), 64'(0));
    chk("rst_rsp_flags", 64'(rsp_flags), 64'(0));
    chk("rst_rsp_err", 64'(rsp_err), 64'(0));
    chk("rst_add_a", 64'(add_a), 64'(0));
    chk("rst_add_opcode", 64'(add_opcode), 64'(0));
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin with every requester held valid
    for (int i = 0; i < N; i++) begin push_rand(i); push_rand(i); end
    grants.delete(); grant_t.delete();
    drain(100);
    chk("rr_count", 64'(grants.size()), 64'(8));
    if (grants.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("rr_order", 64'(grants[i]), 64'(i % N));
      for (int i = 1; i < 5; i++) chk("rr_spacing", 64'(grant_t[i] - grant_t[i-1]), 64'(3));
    end

    // Directed results with explicit expectations
    push_req(2, 32'd5, 32'd7, 5'b00001, 1, 32'd12, 4'b0000, 1'b0);
    drain(20);
    push_req(0, 32'd9, 32'd9, 5'b00011, 1, 32'd0, 4'b1001, 1'b0);
    push_req(3, 32'h7FFF_FFFF, 32'd1, 5'b00010, 1, 32'h8000_0000, 4'b0110, 1'b0);
    push_req(1, 32'h1234_5678, 32'd3, 5'b00111, 1, 32'd0, 4'b0001, 1'b1);
    drain(40);

    // Back-pressure: response held for 10 cycles while another request waits
    rr_mode = 2;
    push_req(1, 32'd100, 32'd23, 5'b00001, 1, 32'd123, 4'b0000, 1'b0);
    wait_rsp_valid("bp_rsp_valid");
    push_rand(3);
    grants.delete();
    repeat (10) step();
    chk("bp_no_grant", 64'(grants.size()), 64'(0));
    rr_mode = 0;
    drain(30);
    chk("bp_next_grant", 64'((grants.size() > 0) ? grants[0] : -1), 64'(3));

    // Reset in RESP drops the operation and clears the pointer
    rr_mode = 2;
    push_req(0, 32'd1, 32'd2, 5'b00001, 1, 32'd3, 4'b0000, 1'b0);
    wait_rsp_valid("mid_rsp_valid");
    @(negedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("mid_rst_rsp_sum", 64'(rsp_sum), 64'(0));
    chk("mid_rst_add_a", 64'(add_a), 64'(0));
    chk("mid_rst_req_ready", 64'(req_ready), 64'(0));
    #1;
    rst_n = 1'b1;
    busy = 0; acc_pend = 0; v = '0; ptr = 0;
    sb.delete();
    rr_mode = 0;
    grants.delete();
    push_req(1, 32'd40, 32'd2, 5'b00001, 1, 32'd42, 4'b0000, 1'b0);
    push_req(0, 32'd10, 32'd4, 5'b00011, 1, 32'd6, 4'b1000, 1'b0);
    drain(30);
    chk("post_rst_first_grant", 64'((grants.size() > 0) ? grants[0] : -1), 64'(0));

    // Randomised traffic with random back-pressure
    rand_gate = 1;
    rr_mode = 1;
    for (int n = 0; n < 300; n++) push_rand($urandom_range(0, N - 1));
    drain(6000);
    rr_mode = 0;
    repeat (2) step();
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
